tile_judge: RTL and testbench
=============================

Name: tile_judge

Overview:
- Parametrised successor to the fixed 3x3 win checker.
- Owns an N x N board register and accepts moves through a valid/ready handshake.
- Rejects illegal moves, alternates players, and after each move runs a 4-cycle directional scan for K-in-a-row through the placed cell.
- Latches winner, winning-tile mask or draw; feeds the display/colour logic and the input controller.

Parameters:
N, 3, board side length (3..8)
K, 3, run length needed to win (2..N)
RW, $clog2(N) (min 1), row/column index width

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
new_game  input  1  synchronous clear request, single-cycle pulse
move_valid  input  1  move request
move_ready  output  1  high only in IDLE
move_row  input  RW  target row, 0 = top
move_col  input  RW  target column, 0 = left
board  output  2*N*N  tile idx = row*N+col occupies bits [2*idx+1:2*idx]; 00 empty, 01 X, 10 O
cur_player  output  2  player to move (01 or 10)
move_err  output  1  one-cycle pulse on rejected move
result_valid  output  1  one-cycle pulse when a move's check completes
game_over  output  1  level, high in OVER
winner  output  2  00 none/draw, else winning player
draw  output  1  level, board full with no winner
win_mask  output  N*N  bit idx set for each tile in the winning run

Behaviour:
- Reset (async, active-high): board=0, cur_player=01, state=IDLE, all other outputs 0 except move_ready=1.
- States: IDLE, CHECK, OVER.
- IDLE: a transfer happens when move_valid && move_ready at a rising edge.
  - Row or column >= N, or tile nonzero: move_err=1 the next cycle, board unchanged, stay IDLE.
  - Otherwise: write cur_player into the tile, latch row/col, increment move_cnt, dir=0, go CHECK.
- CHECK: one direction per cycle, in this order: dir 0 horizontal, 1 vertical, 2 diagonal (down-right), 3 anti-diagonal (down-left).
  - Run = 1 + contiguous cur_player tiles in both senses from the latched cell, clipped at board edges, each sense capped at K-1.
  - Run >= K: set win_mask to the run tiles, winner=cur_player, game_over=1, result_valid pulse, go OVER. Remaining directions are skipped.
  - dir 3 with no win and move_cnt==N*N: draw=1, game_over=1, result_valid pulse, go OVER.
  - dir 3 with no win and the board not full: toggle cur_player, result_valid pulse, go IDLE.
- Latency: accept at edge t; result_valid high during the cycle after edge t+1+d, where d = index of the winning direction (3 if no win). Worst case is 4 cycles after accept.
- OVER: move_ready=0 and moves are ignored with no move_err; outputs hold.
- new_game (any state, priority over a move in the same cycle): next edge clears board, move_cnt, winner, draw, win_mask and game_over; cur_player=01; state=IDLE.
- Reset mid-CHECK: immediate return to reset values, no result_valid.
- move_cnt width is $clog2(N*N+1) and never wraps (max N*N).
- move_ready is low in CHECK, so a held move_valid waits for IDLE.

Decomposition:
- Package tile_judge_pkg holds:
  - tile encodings EMPTY=2'b00, PX=2'b01, PO=2'b10
  - state enum IDLE/CHECK/OVER
  - direction constants DIR_H/DIR_V/DIR_D/DIR_A
  - function tile_idx(row, col)
- Sub-module tile_run_counter: combinational; takes board, row, col, dir and player; returns run length and N*N run mask. It is instanced once and shared across the four CHECK cycles.

Test Plan:
- N=3,K=3 row win: X(0,0) O(1,0) X(0,1) O(1,1) X(0,2).
  - After the last move: result_valid at dir 0, winner=01, win_mask=9'b000000111, game_over=1.
  - A further move_valid gets no ack and no err.
- Anti-diagonal win: X(0,2) O(0,0) X(1,1) O(0,1) X(2,0).
  - Result arrives 4 cycles after accept; win_mask=9'b001010100, winner=01.
- Illegal moves, N=3:
  - Move to an occupied (1,1): move_err pulse, board unchanged, cur_player unchanged.
  - Move to row=3: move_err pulse.
- Draw, N=3: sequence X(0,0) O(0,1) X(0,2) O(1,1) X(1,0) O(1,2) X(2,1) O(2,0) X(2,2).
  - draw=1, winner=00, win_mask=0, game_over=1 after move 9.
- N=4,K=3 interior vertical: X(1,2) X(2,2) X(3,2) interleaved with O moves elsewhere.
  - win_mask bits 6, 10, 14 set; board width is 32 bits.
- Controls: new_game asserted with move_valid in OVER clears everything and ignores the move. Reset asserted mid-CHECK returns all outputs to 0 and cur_player to 01 without waiting for a clock edge.

Source files
------------

// File: rtl/tile_judge_pkg.sv
// Shared encodings, FSM states, scan directions and tile indexing for the
// N x N K-in-a-row judge.
package tile_judge_pkg;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] PX    = 2'b01;
    localparam logic [1:0] PO    = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        OVER  = 2'd2
    } state_t;

    localparam logic [1:0] DIR_H = 2'd0;
    localparam logic [1:0] DIR_V = 2'd1;
    localparam logic [1:0] DIR_D = 2'd2;
    localparam logic [1:0] DIR_A = 2'd3;

    function automatic int unsigned tile_idx(input int unsigned row,
                                             input int unsigned col,
                                             input int unsigned n);
        return row * n + col;
    endfunction

endpackage

// File: rtl/tile_run_counter.sv
// Combinational run measurement through one cell along one direction,
// returning the run length and the mask of tiles that form it.
module tile_run_counter
    import tile_judge_pkg::*;
#(
    parameter int unsigned N  = 3,
    parameter int unsigned K  = 3,
    parameter int unsigned RW = 2,
    parameter int unsigned LW = $clog2(2 * K)
) (
    input  logic [2*N*N-1:0] board,
    input  logic [RW-1:0]    row,
    input  logic [RW-1:0]    col,
    input  logic [1:0]       dir,
    input  logic [1:0]       player,
    output logic [LW-1:0]    run_len_c,
    output logic [N*N-1:0]   run_mask_c
);

    localparam int unsigned IW = (N * N > 1) ? $clog2(N * N) : 1;
    localparam int unsigned BW = $clog2(2 * N * N);

    // True when (rr, cc) lies on the board and holds the given player.
    function automatic logic hit(input logic [2*N*N-1:0] b,
                                 input logic [1:0]       p,
                                 input int               rr,
                                 input int               cc);
        if (rr < 0 || cc < 0 || rr >= int'(N) || cc >= int'(N)) begin
            return 1'b0;
        end
        return b[BW'(2 * tile_idx(32'(rr), 32'(cc), N)) +: 2] == p;
    endfunction

    int   dr;
    int   dc;
    int   rr;
    int   cc;
    int   fwd;
    int   bwd;
    logic fwd_on;
    logic bwd_on;

    always_comb begin
        dr         = 0;
        dc         = 1;
        rr         = 0;
        cc         = 0;
        fwd        = 0;
        bwd        = 0;
        fwd_on     = 1'b1;
        bwd_on     = 1'b1;
        run_mask_c = '0;
        case (dir)
            DIR_H:   begin dr = 0; dc = 1;  end
            DIR_V:   begin dr = 1; dc = 0;  end
            DIR_D:   begin dr = 1; dc = 1;  end
            default: begin dr = 1; dc = -1; end
        endcase
        run_mask_c[IW'(tile_idx(32'(row), 32'(col), N))] = 1'b1;
        // Walk both senses; each stops at the first gap and never exceeds K-1.
        for (int s = 1; s < int'(K); s++) begin
            rr = int'(row) + s * dr;
            cc = int'(col) + s * dc;
            if (fwd_on && hit(board, player, rr, cc)) begin
                fwd = fwd + 1;
                run_mask_c[IW'(tile_idx(32'(rr), 32'(cc), N))] = 1'b1;
            end else begin
                fwd_on = 1'b0;
            end
            rr = int'(row) - s * dr;
            cc = int'(col) - s * dc;
            if (bwd_on && hit(board, player, rr, cc)) begin
                bwd = bwd + 1;
                run_mask_c[IW'(tile_idx(32'(rr), 32'(cc), N))] = 1'b1;
            end else begin
                bwd_on = 1'b0;
            end
        end
        run_len_c = LW'(1 + fwd + bwd);
    end

endmodule

// File: rtl/tile_judge.sv
// N x N board owner: accepts moves, rejects illegal ones, alternates players
// and scans the four directions through each placed tile for K-in-a-row.
module tile_judge
    import tile_judge_pkg::*;
#(
    parameter int unsigned N  = 3,
    parameter int unsigned K  = 3,
    parameter int unsigned RW = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              new_game,
    input  logic              move_valid,
    output logic              move_ready,
    input  logic [RW-1:0]     move_row,
    input  logic [RW-1:0]     move_col,
    output logic [2*N*N-1:0]  board,
    output logic [1:0]        cur_player,
    output logic              move_err,
    output logic              result_valid,
    output logic              game_over,
    output logic [1:0]        winner,
    output logic              draw,
    output logic [N*N-1:0]    win_mask
);

    localparam int unsigned NN = N * N;
    localparam int unsigned CW = $clog2(NN + 1);
    localparam int unsigned LW = $clog2(2 * K);
    localparam int unsigned BW = $clog2(2 * NN);

    state_t            state;
    state_t            state_n;
    logic [RW-1:0]     row_q;
    logic [RW-1:0]     row_n;
    logic [RW-1:0]     col_q;
    logic [RW-1:0]     col_n;
    logic [1:0]        dir_q;
    logic [1:0]        dir_n;
    logic [CW-1:0]     move_cnt;
    logic [CW-1:0]     cnt_n;
    logic [2*NN-1:0]   board_n;
    logic [1:0]        cur_player_n;
    logic              ready_n;
    logic              err_n;
    logic              rv_n;
    logic              over_n;
    logic [1:0]        winner_n;
    logic              draw_n;
    logic [NN-1:0]     mask_n;
    logic              in_range;
    logic [BW-1:0]     slot;
    logic [LW-1:0]     run_len_c;
    logic [NN-1:0]     run_mask_c;

    tile_run_counter #(
        .N  (N),
        .K  (K),
        .RW (RW),
        .LW (LW)
    ) u_run (
        .board      (board),
        .row        (row_q),
        .col        (col_q),
        .dir        (dir_q),
        .player     (cur_player),
        .run_len_c  (run_len_c),
        .run_mask_c (run_mask_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            board        <= '0;
            cur_player   <= PX;
            row_q        <= '0;
            col_q        <= '0;
            dir_q        <= DIR_H;
            move_cnt     <= '0;
            move_ready   <= 1'b1;
            move_err     <= 1'b0;
            result_valid <= 1'b0;
            game_over    <= 1'b0;
            winner       <= EMPTY;
            draw         <= 1'b0;
            win_mask     <= '0;
        end else begin
            state        <= state_n;
            board        <= board_n;
            cur_player   <= cur_player_n;
            row_q        <= row_n;
            col_q        <= col_n;
            dir_q        <= dir_n;
            move_cnt     <= cnt_n;
            move_ready   <= ready_n;
            move_err     <= err_n;
            result_valid <= rv_n;
            game_over    <= over_n;
            winner       <= winner_n;
            draw         <= draw_n;
            win_mask     <= mask_n;
        end
    end

    always_comb begin
        state_n      = state;
        board_n      = board;
        cur_player_n = cur_player;
        row_n        = row_q;
        col_n        = col_q;
        dir_n        = dir_q;
        cnt_n        = move_cnt;
        err_n        = 1'b0;
        rv_n         = 1'b0;
        over_n       = game_over;
        winner_n     = winner;
        draw_n       = draw;
        mask_n       = win_mask;
        in_range     = (32'(move_row) < N) && (32'(move_col) < N);
        slot         = BW'(2 * tile_idx(32'(move_row), 32'(move_col), N));

        if (new_game) begin
            state_n      = IDLE;
            board_n      = '0;
            cur_player_n = PX;
            dir_n        = DIR_H;
            cnt_n        = '0;
            over_n       = 1'b0;
            winner_n     = EMPTY;
            draw_n       = 1'b0;
            mask_n       = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (move_valid && move_ready) begin
                        if (in_range && board[slot +: 2] == EMPTY) begin
                            board_n[slot +: 2] = cur_player;
                            row_n              = move_row;
                            col_n              = move_col;
                            cnt_n              = move_cnt + CW'(1);
                            dir_n              = DIR_H;
                            state_n            = CHECK;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end
                CHECK: begin
                    // One direction per cycle; a win ends the scan early.
                    if (run_len_c >= LW'(K)) begin
                        mask_n   = run_mask_c;
                        winner_n = cur_player;
                        over_n   = 1'b1;
                        rv_n     = 1'b1;
                        state_n  = OVER;
                    end else if (dir_q == DIR_A) begin
                        rv_n = 1'b1;
                        if (move_cnt == CW'(NN)) begin
                            draw_n  = 1'b1;
                            over_n  = 1'b1;
                            state_n = OVER;
                        end else begin
                            cur_player_n = (cur_player == PX) ? PO : PX;
                            state_n      = IDLE;
                        end
                    end else begin
                        dir_n = dir_q + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
        ready_n = (state_n == IDLE);
    end

endmodule

// File: tb/tb_tile_judge.sv
// Directed scoreboard bench for tile_judge at N=3,K=3 and N=4,K=3.
module tb_tile_judge;
    import tile_judge_pkg::*;

    localparam int K_CONT = 0;
    localparam int K_ERR  = 1;
    localparam int K_WIN  = 2;
    localparam int K_DRAW = 3;

    typedef struct {
        int          kind;
        logic [1:0]  win;
        logic [15:0] mask;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        new_game;
    logic        mv;
    logic        sel;
    logic [1:0]  mrow;
    logic [1:0]  mcol;

    logic        rdy3, err3, rv3, go3, draw3;
    logic [1:0]  cur3, win3;
    logic [17:0] board3;
    logic [8:0]  mask3;
    logic        rdy4, err4, rv4, go4, draw4;
    logic [1:0]  cur4, win4;
    logic [31:0] board4;
    logic [15:0] mask4;

    logic        rdy_v, err_v, rv_v, go_v, draw_v;
    logic [1:0]  cur_v, win_v;
    logic [31:0] brd_v;
    logic [15:0] mask_v;

    int          nchk = 0;
    int          nfail = 0;
    exp_t        sb[$];
    logic [31:0] mb;
    logic [1:0]  mcp;

    always #5 clk = ~clk;

    tile_judge #(.N(3), .K(3)) u3 (
        .clk(clk), .reset(reset), .new_game(new_game),
        .move_valid(mv && !sel), .move_ready(rdy3),
        .move_row(mrow), .move_col(mcol), .board(board3),
        .cur_player(cur3), .move_err(err3), .result_valid(rv3),
        .game_over(go3), .winner(win3), .draw(draw3), .win_mask(mask3)
    );

    tile_judge #(.N(4), .K(3)) u4 (
        .clk(clk), .reset(reset), .new_game(new_game),
        .move_valid(mv && sel), .move_ready(rdy4),
        .move_row(mrow), .move_col(mcol), .board(board4),
        .cur_player(cur4), .move_err(err4), .result_valid(rv4),
        .game_over(go4), .winner(win4), .draw(draw4), .win_mask(mask4)
    );

    always_comb begin
        if (sel) begin
            rdy_v = rdy4; err_v = err4; rv_v = rv4; go_v = go4; draw_v = draw4;
            cur_v = cur4; win_v = win4; brd_v = board4; mask_v = mask4;
        end else begin
            rdy_v = rdy3; err_v = err3; rv_v = rv3; go_v = go3; draw_v = draw3;
            cur_v = cur3; win_v = win3; brd_v = 32'(board3); mask_v = 16'(mask3);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic move(input int r, input int c, input int kind,
                        input logic [1:0] w, input logic [15:0] m, input int lat);
        exp_t e;
        int   n;
        int   l;
        int   side;
        side = sel ? 4 : 3;
        n = 0;
        while (!rdy_v && n < 20) begin
            step();
            n++;
        end
        check("ready", 32'(rdy_v), 32'd1);
        mrow = 2'(r);
        mcol = 2'(c);
        mv   = 1'b1;
        e.kind = kind; e.win = w; e.mask = m; e.lat = lat;
        sb.push_back(e);
        if (kind != K_ERR) mb[5'(2 * (r * side + c)) +: 2] = mcp;
        step();
        mv = 1'b0;
        l = 0;
        while (!err_v && !rv_v && l < 8) begin
            step();
            l++;
        end
        e = sb.pop_front();
        if (e.kind == K_CONT) mcp = (mcp == PX) ? PO : PX;
        check("err",     32'(err_v),  32'(e.kind == K_ERR));
        check("rv",      32'(rv_v),   32'(e.kind != K_ERR));
        check("latency", l,           e.lat);
        check("board",   brd_v,       mb);
        check("cur",     32'(cur_v),  32'(mcp));
        check("winner",  32'(win_v),  32'(e.win));
        check("mask",    32'(mask_v), 32'(e.mask));
        check("draw",    32'(draw_v), 32'(e.kind == K_DRAW));
        check("over",    32'(go_v),   32'(e.kind >= K_WIN));
        step();
        check("pulse", 32'({err_v, rv_v}), 32'd0);
    endtask

    task automatic clear_game();
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        mb  = '0;
        mcp = PX;
    endtask

    initial begin
        logic rv_seen;
        reset = 1'b1; new_game = 1'b0; mv = 1'b0; sel = 1'b0;
        mrow = '0; mcol = '0; mb = '0; mcp = PX;
        step();
        check("rst_ready", 32'(rdy_v), 32'd1);
        check("rst_board", brd_v, 32'd0);
        check("rst_cur",   32'(cur_v), 32'(PX));
        check("rst_flags", 32'({err_v, rv_v, go_v, draw_v, win_v}), 32'd0);
        check("rst_mask",  32'(mask_v), 32'd0);
        step();
        reset = 1'b0;
        step();

        // Row win on the top row.
        move(0, 0, K_CONT, 2'b00, 16'h0, 4);
        move(1, 0, K_CONT, 2'b00, 16'h0, 4);
        move(0, 1, K_CONT, 2'b00, 16'h0, 4);
        move(1, 1, K_CONT, 2'b00, 16'h0, 4);
        move(0, 2, K_WIN,  PX,    16'h0007, 1);

        // Moves in OVER are neither accepted nor flagged.
        mrow = 2'd2; mcol = 2'd2; mv = 1'b1;
        repeat (3) begin
            step();
            check("over_ready", 32'(rdy_v), 32'd0);
            check("over_err",   32'(err_v), 32'd0);
            check("over_board", brd_v, mb);
        end

        // new_game wins over a simultaneous move.
        new_game = 1'b1;
        step();
        new_game = 1'b0; mv = 1'b0; mb = '0; mcp = PX;
        check("ng_board", brd_v, 32'd0);
        check("ng_flags", 32'({go_v, draw_v, win_v}), 32'd0);
        check("ng_mask",  32'(mask_v), 32'd0);
        check("ng_cur",   32'(cur_v), 32'(PX));
        check("ng_ready", 32'(rdy_v), 32'd1);
        step();
        check("ng_board2", brd_v, 32'd0);

        // Anti-diagonal win with illegal moves along the way.
        move(0, 2, K_CONT, 2'b00, 16'h0, 4);
        move(0, 0, K_CONT, 2'b00, 16'h0, 4);
        move(1, 1, K_CONT, 2'b00, 16'h0, 4);
        move(1, 1, K_ERR,  2'b00, 16'h0, 0);
        move(3, 0, K_ERR,  2'b00, 16'h0, 0);
        move(0, 1, K_CONT, 2'b00, 16'h0, 4);
        move(2, 0, K_WIN,  PX,    16'h0054, 4);

        // Full board, no winner.
        clear_game();
        move(0, 0, K_CONT, 2'b00, 16'h0, 4);
        move(0, 1, K_CONT, 2'b00, 16'h0, 4);
        move(0, 2, K_CONT, 2'b00, 16'h0, 4);
        move(1, 1, K_CONT, 2'b00, 16'h0, 4);
        move(1, 0, K_CONT, 2'b00, 16'h0, 4);
        move(1, 2, K_CONT, 2'b00, 16'h0, 4);
        move(2, 1, K_CONT, 2'b00, 16'h0, 4);
        move(2, 0, K_CONT, 2'b00, 16'h0, 4);
        move(2, 2, K_DRAW, 2'b00, 16'h0, 4);

        // Asynchronous reset in the middle of a scan.
        clear_game();
        step();
        check("mid_ready", 32'(rdy_v), 32'd1);
        mrow = 2'd1; mcol = 2'd1; mv = 1'b1;
        step();
        mv = 1'b0;
        check("mid_busy", 32'(rdy_v), 32'd0);
        reset = 1'b1;
        #1;
        check("arst_board", brd_v, 32'd0);
        check("arst_cur",   32'(cur_v), 32'(PX));
        check("arst_ready", 32'(rdy_v), 32'd1);
        check("arst_flags", 32'({rv_v, go_v, err_v}), 32'd0);
        rv_seen = 1'b0;
        repeat (5) begin
            step();
            rv_seen = rv_seen | rv_v;
        end
        check("arst_no_rv", 32'(rv_seen), 32'd0);
        reset = 1'b0;
        step();

        // N=4, K=3 interior vertical win.
        sel = 1'b1; mb = '0; mcp = PX;
        move(1, 2, K_CONT, 2'b00, 16'h0, 4);
        move(0, 0, K_CONT, 2'b00, 16'h0, 4);
        move(2, 2, K_CONT, 2'b00, 16'h0, 4);
        move(0, 1, K_CONT, 2'b00, 16'h0, 4);
        move(3, 2, K_WIN,  PX,    16'h4440, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

endmodule
